y86_dmem_responder: RTL and testbench
=====================================

# y86_dmem_responder

Data-memory responder for the pipelined Y86-64 processor; it is the memory-side end of the M-stage request interface. It accepts one 64-bit read or write request at a time over a valid/ready handshake, waits a fixed access latency, and returns a response carrying read data (valM) and an error flag (dmem_error). It replaces the zero-latency combinational data memory, so the pipeline's M stage must stall until the response arrives.

## Interface
- MEM_BYTES, 1024: size of the byte-addressed data memory; must be a multiple of 8 and ≥ 8.
- LATENCY, 2: cycles from request acceptance to resp_valid; must be ≥ 1.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  M stage presents a request.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = write (rmmovq/pushq/call), 0 = read (mrmovq/popq/ret).
- req_addr  in  64  byte address (valE or valA as chosen by the M stage).
- req_wdata  in  64  write data (valA or valP).
- resp_valid  out  1  response available.
- resp_ready  in  1  M stage consumes the response.
- resp_rdata  out  64  read data; 0 for writes and errors.
- resp_error  out  1  address out of range; drives stat ADR in the pipeline.
- busy  out  1  high in WAIT or RESP; the pipeline uses it as an M-stage stall.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready = 1. When req_valid is high at a rising edge, latch write, addr, and wdata, and load cnt = LATENCY−1. Go to WAIT if LATENCY > 1, otherwise go to RESP.
- WAIT: cnt decrements each cycle. On the edge where cnt == 1, go to RESP and perform the access in that same edge.
- Access, when range check passes:
  - Write: stores bytes addr..addr+7 little-endian (byte 0 = wdata[7:0]).
  - Read: loads the same bytes into resp_rdata.
- Range check: error when addr > MEM_BYTES−8, compared as an unsigned 64-bit value. This comparison must not wrap for addresses near 2^64. There is no alignment requirement.
- Error access: memory is unchanged, resp_rdata = 0, resp_error = 1.
- RESP: resp_valid = 1, with rdata and error held stable. When resp_ready is high, return to IDLE on that edge. A new request is accepted at the earliest on the following edge, so throughput is one request per LATENCY+1 cycles minimum.
- Request inputs are ignored outside IDLE.
- Memory contents are not reset; unwritten locations read as X in simulation.

## Timing
- Reset values:
  - state = IDLE, cnt = 0.
  - req_ready = 1, resp_valid = 0, busy = 0.
  - resp_rdata = 0, resp_error = 0.
- Latency: request accepted at edge N gives resp_valid high starting at cycle N+LATENCY.
- Read-after-write to the same address in back-to-back transactions returns the new data, because the write commits before RESP is entered.
- Reset asserted mid-operation:
  - Returns to IDLE immediately.
  - A pending write that has not yet reached RESP is discarded.
  - A write already committed stays in memory.
- resp_ready high while not in RESP has no effect.
- req_valid and resp_ready high together in RESP: the request is not accepted; the response completes.

## Structure
- Package y86_mem_pkg holds:
  - the state enum (IDLE/WAIT/RESP);
  - WORD_BYTES = 8;
  - stat codes AOK/HLT/ADR/INS, shared with the pipeline stat logic.
- Sub-module y86_dmem_array holds the byte array with a synchronous 64-bit little-endian read/write port and a write enable. The responder holds the FSM, counter, range check, and output registers.

## Test plan
- Write then read, LATENCY=2: write addr 0x40, data 0x1122334455667788, resp_ready=1. resp_valid goes high 2 cycles after acceptance with error 0. A following read of 0x40 returns 0x1122334455667788.
- Little-endian / unaligned: after the previous write, read addr 0x41 gives byte 0 of the result = 0x77. Read addr 0x47 gives byte 0 = 0x11.
- Range error, MEM_BYTES=1024:
  - write 0x3F9 → error 1, and a later read of 0x3F8 is unchanged;
  - read 0xFFFFFFFFFFFFFFFC → error 1, rdata 0, with no wraparound;
  - read 0x3F8 → error 0.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP. resp_valid and rdata stay stable, req_ready stays 0, and a req_valid pulse is ignored. Raising resp_ready returns to IDLE on the next edge.
- Reset mid-op: assert rst during WAIT of a write to 0x80 that would store 0xDEAD. Outputs return to reset values asynchronously. A read of 0x80 afterwards does not return 0xDEAD.
- LATENCY=1 and back-to-back: 4 reads with req_valid held high and resp_ready=1. Each request is accepted every 2 cycles, and each response arrives 1 cycle after its acceptance.

Source files
------------

// File: rtl/y86_dmem_responder_pkg.sv
// Shared definitions for the Y86-64 data-memory responder and the pipeline
// stat logic.
package y86_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int unsigned WORD_BYTES = 8;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

endpackage

// File: rtl/y86_dmem_responder_if.sv
// M-stage request/response channel between the pipeline and the data memory.
interface y86_dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_error;
  logic        busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error, busy
  );
endinterface

// File: rtl/y86_dmem_responder_array.sv
// Byte-addressed data memory with one synchronous 64-bit little-endian port.
// The caller guarantees addr+7 stays inside the array.
module y86_dmem_array
  import y86_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  localparam int unsigned AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [7:0] mem [MEM_BYTES];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      if (we)
        mem[addr + AW'(i)] <= wdata[8*i +: 8];
      if (re)
        rdata[8*i +: 8] <= mem[addr + AW'(i)];
    end
  end

endmodule

// File: rtl/y86_dmem_responder.sv
// Fixed-latency data-memory responder: accepts one request, performs the
// access on the edge that enters RESP, and holds the response until consumed.
module y86_dmem_responder
  import y86_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  y86_dmem_responder_if.slave  bus
);

  localparam int unsigned AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int unsigned CW = $clog2(LATENCY + 1);
  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - WORD_BYTES);

  state_t         state, state_next;
  logic [CW-1:0]  cnt;
  logic           lat_write;
  logic [63:0]    lat_addr, lat_wdata;
  logic           rdata_ok, err_q;

  logic           acc_fire, acc_write, acc_err;
  logic [63:0]    acc_addr, acc_wdata;
  logic           arr_we, arr_re;
  logic [63:0]    arr_rdata;

  // With LATENCY == 1 the access happens on the accept edge, straight from
  // the request inputs; otherwise it uses the latched copy.
  always_comb begin
    state_next = state;
    acc_fire   = 1'b0;
    acc_write  = lat_write;
    acc_addr   = lat_addr;
    acc_wdata  = lat_wdata;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (LATENCY > 1) begin
            state_next = WAIT;
          end else begin
            state_next = RESP;
            acc_fire   = 1'b1;
            acc_write  = bus.req_write;
            acc_addr   = bus.req_addr;
            acc_wdata  = bus.req_wdata;
          end
        end
      end
      WAIT: begin
        if (cnt == CW'(1)) begin
          state_next = RESP;
          acc_fire   = 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Plain unsigned compare against the top legal base: no addition on addr,
  // so addresses near 2^64 cannot wrap into range.
  assign acc_err = (acc_addr > MAX_ADDR);
  assign arr_we  = acc_fire &  acc_write & ~acc_err;
  assign arr_re  = acc_fire & ~acc_write & ~acc_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_ok  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        cnt       <= CW'(LATENCY - 1);
        lat_write <= bus.req_write;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
      end else if (state == WAIT) begin
        cnt <= cnt - CW'(1);
      end
      if (acc_fire) begin
        rdata_ok <= ~acc_write & ~acc_err;
        err_q    <= acc_err;
      end else if (state == RESP && bus.resp_ready) begin
        rdata_ok <= 1'b0;
        err_q    <= 1'b0;
      end
    end
  end

  y86_dmem_array #(
    .MEM_BYTES (MEM_BYTES)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (acc_addr[AW-1:0]),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.busy       = (state != IDLE);
  assign bus.resp_rdata = rdata_ok ? arr_rdata : '0;
  assign bus.resp_error = err_q;

endmodule

// File: tb/tb_y86_dmem_responder.sv
// Randomised self-checking bench for y86_dmem_responder (LATENCY 2 and 1).
module tb_y86_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  y86_dmem_responder_if i2 ();
  y86_dmem_responder_if i1 ();

  y86_dmem_responder #(.MEM_BYTES(1024), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(i2));
  y86_dmem_responder #(.MEM_BYTES(1024), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(i1));

  // Reference model of dut2's memory: only bytes ever written are known.
  logic [7:0] mem_m [int];

  function automatic void model(input logic w, input logic [63:0] a, input logic [63:0] d,
                                output logic [63:0] rd, output logic [63:0] mask,
                                output logic er);
    rd = '0; mask = '1; er = (a > 64'd1016);
    if (!er) begin
      for (int k = 0; k < 8; k++) begin
        if (w) mem_m[int'(a) + k] = d[8*k +: 8];
        else if (mem_m.exists(int'(a) + k)) rd[8*k +: 8] = mem_m[int'(a) + k];
        else mask[8*k +: 8] = 8'h00;
      end
    end
  endfunction

  // Drives one dut2 transaction with resp_ready=1; lat counts cycles from accept to resp_valid.
  task automatic txn2(input logic w, input logic [63:0] a, input logic [63:0] d,
                      output logic [63:0] rd, output logic er, output int lat);
    @(negedge clk);
    i2.req_valid = 1'b1; i2.req_write = w; i2.req_addr = a; i2.req_wdata = d;
    i2.resp_ready = 1'b1;
    lat = 0;
    while (!i2.req_ready && lat < 20) begin @(negedge clk); lat++; end
    @(negedge clk);
    i2.req_valid = 1'b0;
    lat = 1;
    while (!i2.resp_valid && lat < 20) begin @(negedge clk); lat++; end
    rd = i2.resp_rdata; er = i2.resp_error;
  endtask

  task automatic test_reset();
    checks += 5;
    if (i2.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b want 1", i2.req_ready); end
    if (i2.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %0b want 0", i2.resp_valid); end
    if (i2.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", i2.busy); end
    if (i2.resp_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", i2.resp_rdata); end
    if (i2.resp_error !== 1'b0) begin errors++; $display("FAIL reset_error got %0b want 0", i2.resp_error); end
    checks += 2;
    if (i1.req_ready !== 1'b1) begin errors++; $display("FAIL reset1_req_ready got %0b want 1", i1.req_ready); end
    if (i1.busy !== 1'b0) begin errors++; $display("FAIL reset1_busy got %0b want 0", i1.busy); end
  endtask

  task automatic test_write_read();
    logic [63:0] rd, er_d, mask; logic er, ee; int lat;
    model(1'b1, 64'h40, 64'h1122334455667788, er_d, mask, ee);
    txn2(1'b1, 64'h40, 64'h1122334455667788, rd, er, lat);
    checks += 3;
    if (lat !== 2) begin errors++; $display("FAIL wr_latency got %0d want 2", lat); end
    if (er !== 1'b0) begin errors++; $display("FAIL wr_error got %0b want 0", er); end
    if (rd !== 64'h0) begin errors++; $display("FAIL wr_rdata got %h want 0", rd); end
    txn2(1'b0, 64'h40, 64'h0, rd, er, lat);
    checks += 2;
    if (rd !== 64'h1122334455667788) begin errors++; $display("FAIL rd_data got %h want 1122334455667788", rd); end
    if (lat !== 2) begin errors++; $display("FAIL rd_latency got %0d want 2", lat); end
  endtask

  task automatic test_unaligned();
    logic [63:0] rd; logic er; int lat;
    txn2(1'b0, 64'h41, 64'h0, rd, er, lat);
    checks += 2;
    if (rd[7:0] !== 8'h77) begin errors++; $display("FAIL unaligned_41 got %h want 77", rd[7:0]); end
    if (rd[55:0] !== 56'h11223344556677) begin errors++; $display("FAIL unaligned_41_word got %h want 11223344556677", rd[55:0]); end
    txn2(1'b0, 64'h47, 64'h0, rd, er, lat);
    checks += 1;
    if (rd[7:0] !== 8'h11) begin errors++; $display("FAIL unaligned_47 got %h want 11", rd[7:0]); end
  endtask

  task automatic test_range();
    logic [63:0] rd, md, mask; logic er, ee; int lat;
    model(1'b1, 64'h3F8, 64'hA5A5_0102_0304_5A5A, md, mask, ee);
    txn2(1'b1, 64'h3F8, 64'hA5A5_0102_0304_5A5A, rd, er, lat);
    checks += 1;
    if (er !== 1'b0) begin errors++; $display("FAIL range_wr3f8_error got %0b want 0", er); end
    txn2(1'b1, 64'h3F9, 64'hFFFF_FFFF_FFFF_FFFF, rd, er, lat);
    checks += 1;
    if (er !== 1'b1) begin errors++; $display("FAIL range_wr3f9_error got %0b want 1", er); end
    txn2(1'b0, 64'h3F8, 64'h0, rd, er, lat);
    checks += 2;
    if (er !== 1'b0) begin errors++; $display("FAIL range_rd3f8_error got %0b want 0", er); end
    if (rd !== 64'hA5A5_0102_0304_5A5A) begin errors++; $display("FAIL range_rd3f8_data got %h want a5a501020304 5a5a", rd); end
    txn2(1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, rd, er, lat);
    checks += 2;
    if (er !== 1'b1) begin errors++; $display("FAIL range_wrap_error got %0b want 1", er); end
    if (rd !== 64'h0) begin errors++; $display("FAIL range_wrap_rdata got %h want 0", rd); end
  endtask

  task automatic test_random();
    logic [63:0] a, d, rd, md, mask; logic w, er, ee; int lat;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0: a = 64'd1017 + 64'($urandom_range(0, 200));
        1: a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
        default: a = 64'($urandom_range(512, 600));
      endcase
      w = 1'($urandom_range(0, 1));
      d = {$urandom, $urandom};
      model(w, a, d, md, mask, ee);
      txn2(w, a, d, rd, er, lat);
      checks += 3;
      if (lat !== 2) begin errors++; $display("FAIL rand_latency[%0d] got %0d want 2", n, lat); end
      if (er !== ee) begin errors++; $display("FAIL rand_error[%0d] addr %h got %0b want %0b", n, a, er, ee); end
      if ((rd & mask) !== (md & mask)) begin
        errors++; $display("FAIL rand_rdata[%0d] addr %h w %0b got %h want %h mask %h", n, a, w, rd, md, mask);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] md, mask, rd; logic ee, er; int t, lat;
    model(1'b0, 64'h40, 64'h0, md, mask, ee);
    @(negedge clk);
    i2.req_valid = 1'b1; i2.req_write = 1'b0; i2.req_addr = 64'h40; i2.resp_ready = 1'b0;
    @(negedge clk);
    i2.req_valid = 1'b0;
    t = 0;
    while (!i2.resp_valid && t < 20) begin @(negedge clk); t++; end
    for (int i = 0; i < 5; i++) begin
      checks += 3;
      if (i2.resp_valid !== 1'b1) begin errors++; $display("FAIL bp_resp_valid[%0d] got %0b want 1", i, i2.resp_valid); end
      if (i2.req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d] got %0b want 0", i, i2.req_ready); end
      if (i2.resp_rdata !== md) begin errors++; $display("FAIL bp_rdata[%0d] got %h want %h", i, i2.resp_rdata, md); end
      if (i == 1) begin
        i2.req_valid = 1'b1; i2.req_write = 1'b1; i2.req_wdata = 64'h0BAD_0BAD_0BAD_0BAD;
      end
      if (i == 2) i2.req_valid = 1'b0;
      @(negedge clk);
    end
    i2.resp_ready = 1'b1;
    @(negedge clk);
    checks += 2;
    if (i2.resp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %0b want 0", i2.resp_valid); end
    if (i2.req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0b want 1", i2.req_ready); end
    txn2(1'b0, 64'h40, 64'h0, rd, er, lat);
    checks += 1;
    if (rd !== md) begin errors++; $display("FAIL bp_ignored_write got %h want %h", rd, md); end
  endtask

  task automatic test_reset_midop();
    logic [63:0] rd, md, mask; logic er, ee; int lat;
    model(1'b1, 64'h80, 64'h5555, md, mask, ee);
    txn2(1'b1, 64'h80, 64'h5555, rd, er, lat);
    @(negedge clk);
    i2.req_valid = 1'b1; i2.req_write = 1'b1; i2.req_addr = 64'h80; i2.req_wdata = 64'hDEAD;
    @(negedge clk);
    i2.req_valid = 1'b0;
    checks += 1;
    if (i2.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_wait got %0b want 1", i2.busy); end
    #2 rst = 1'b1;
    #1;
    checks += 3;
    if (i2.busy !== 1'b0) begin errors++; $display("FAIL mid_async_busy got %0b want 0", i2.busy); end
    if (i2.req_ready !== 1'b1) begin errors++; $display("FAIL mid_async_ready got %0b want 1", i2.req_ready); end
    if (i2.resp_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got %0b want 0", i2.resp_valid); end
    @(negedge clk) rst = 1'b0;
    txn2(1'b0, 64'h80, 64'h0, rd, er, lat);
    checks += 1;
    if (rd !== 64'h5555) begin errors++; $display("FAIL mid_discard got %h want 5555", rd); end
    // Reset while in RESP: the write has already committed.
    @(negedge clk);
    i2.req_valid = 1'b1; i2.req_write = 1'b1; i2.req_addr = 64'h88; i2.req_wdata = 64'hCAFE_F00D; i2.resp_ready = 1'b0;
    @(negedge clk) i2.req_valid = 1'b0;
    @(negedge clk);
    checks += 1;
    if (i2.resp_valid !== 1'b1) begin errors++; $display("FAIL mid_resp_valid got %0b want 1", i2.resp_valid); end
    #2 rst = 1'b1;
    #1;
    checks += 1;
    if (i2.resp_valid !== 1'b0) begin errors++; $display("FAIL mid_resp_async got %0b want 0", i2.resp_valid); end
    @(negedge clk) rst = 1'b0;
    model(1'b1, 64'h88, 64'hCAFE_F00D, md, mask, ee);
    txn2(1'b0, 64'h88, 64'h0, rd, er, lat);
    checks += 1;
    if (rd !== 64'hCAFE_F00D) begin errors++; $display("FAIL mid_committed got %h want cafef00d", rd); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] addr_q [8], data_q [8], exp_q [8];
    int acc_cyc [8];
    int ka = 0, kr = 0, cyc = 0;
    for (int k = 0; k < 4; k++) begin
      addr_q[k] = 64'h100 + 64'(16 * k) + 64'($urandom_range(0, 7));
      data_q[k] = {$urandom, $urandom};
      exp_q[k] = '0;
      addr_q[k+4] = addr_q[k]; data_q[k+4] = '0; exp_q[k+4] = data_q[k];
    end
    @(negedge clk);
    i1.resp_ready = 1'b1;
    while (kr < 8 && cyc < 60) begin
      if (i1.resp_valid) begin
        checks += 3;
        if (i1.resp_rdata !== exp_q[kr]) begin errors++; $display("FAIL b2b_rdata[%0d] got %h want %h", kr, i1.resp_rdata, exp_q[kr]); end
        if (i1.resp_error !== 1'b0) begin errors++; $display("FAIL b2b_error[%0d] got %0b want 0", kr, i1.resp_error); end
        if (cyc - acc_cyc[kr] !== 1) begin errors++; $display("FAIL b2b_latency[%0d] got %0d want 1", kr, cyc - acc_cyc[kr]); end
        kr++;
      end
      if (i1.req_ready) begin
        if (ka < 8) begin
          i1.req_valid = 1'b1; i1.req_write = (ka < 4);
          i1.req_addr = addr_q[ka]; i1.req_wdata = data_q[ka];
          acc_cyc[ka] = cyc;
          if (ka > 0) begin
            checks += 1;
            if (acc_cyc[ka] - acc_cyc[ka-1] !== 2) begin
              errors++; $display("FAIL b2b_spacing[%0d] got %0d want 2", ka, acc_cyc[ka] - acc_cyc[ka-1]);
            end
          end
          ka++;
        end else i1.req_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    i1.req_valid = 1'b0;
    checks += 1;
    if (kr !== 8) begin errors++; $display("FAIL b2b_timeout got %0d responses want 8", kr); end
  endtask

  initial begin
    i2.req_valid = 1'b0; i2.req_write = 1'b0; i2.req_addr = '0; i2.req_wdata = '0; i2.resp_ready = 1'b1;
    i1.req_valid = 1'b0; i1.req_write = 1'b0; i1.req_addr = '0; i1.req_wdata = '0; i1.resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    test_reset();
    test_write_read();
    test_unaligned();
    test_range();
    test_backpressure();
    test_reset_midop();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
